// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory controller running one req/addr_ok/data_ok bus transaction per access.
// Bus outputs are registered; the stall to hazard is combinational and independent of pipe_stall_i.
module dmem_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_en_i,
    input  logic              mem_wr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic              except_i,
    input  logic              pipe_stall_i,
    output logic              mem_stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              req_o,
    output logic              wr_o,
    output logic [1:0]        size_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              addr_ok_i,
    input  logic              data_ok_i,
    input  logic [DATA_W-1:0] rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, nxt;
    logic start, resp;
    assign start = (state == IDLE) & mem_en_i & ~except_i;
    // a response only counts once the request has been accepted
    assign resp = data_ok_i & (((state == REQ) & addr_ok_i) | (state == WAIT));
    assign mem_stall_o = mem_en_i & ~except_i & (state != DONE);
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? REQ : IDLE;
            REQ:     nxt = addr_ok_i ? (data_ok_i ? DONE : WAIT) : REQ;
            WAIT:    nxt = data_ok_i ? DONE : WAIT;
            default: nxt = pipe_stall_i ? DONE : IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            req_o   <= 1'b0;
            wr_o    <= 1'b0;
            size_o  <= 2'd0;
            addr_o  <= '0;
            wdata_o <= '0;
            rdata_o <= '0;
        end else begin
            state <= nxt;
            req_o <= (nxt == REQ);
            if (start) begin
                wr_o    <= mem_wr_i;
                size_o  <= (mem_size_i == 2'd3) ? 2'd2 : mem_size_i;
                addr_o  <= mem_addr_i;
                wdata_o <= mem_wdata_i;
            end
            if (resp && !wr_o)
                rdata_o <= rdata_i;
        end
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed checks of dmem_access_ctrl; inputs change and outputs are sampled just after each falling edge.
module tb_dmem_access_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en_i, mem_wr_i, except_i, pipe_stall_i;
    logic [1:0]  mem_size_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        mem_stall_o, req_o, wr_o;
    logic [1:0]  size_o;
    logic [31:0] rdata_o, addr_o, wdata_o;
    logic        addr_ok_i, data_ok_i;
    logic [31:0] rdata_i;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_en_i(mem_en_i), .mem_wr_i(mem_wr_i), .mem_size_i(mem_size_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .except_i(except_i), .pipe_stall_i(pipe_stall_i),
        .mem_stall_o(mem_stall_o), .rdata_o(rdata_o),
        .req_o(req_o), .wr_o(wr_o), .size_o(size_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .addr_ok_i(addr_ok_i), .data_ok_i(data_ok_i), .rdata_i(rdata_i)
    );

    task automatic test_reset();
        rst = 1'b1; mem_en_i = 0; mem_wr_i = 0; mem_size_i = 0; mem_addr_i = 0; mem_wdata_i = 0;
        except_i = 0; pipe_stall_i = 0; addr_ok_i = 0; data_ok_i = 0; rdata_i = 0;
        repeat (2) @(negedge clk);
        #1;
        tests++; if (req_o !== 1'b0) begin fails++; $display("FAIL reset_req: got %b expected 0", req_o); end
        tests++; if ({wr_o, size_o} !== 3'b0) begin fails++; $display("FAIL reset_wr_size: got %b expected 000", {wr_o, size_o}); end
        tests++; if (addr_o !== 32'h0 || wdata_o !== 32'h0) begin fails++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", addr_o, wdata_o); end
        tests++; if (rdata_o !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata_o); end
        tests++; if (mem_stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", mem_stall_o); end
        rst = 1'b0;
    endtask

    task automatic test_load_word();
        @(negedge clk); mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2; mem_addr_i = 32'h8000_0010; #1;
        tests++; if (mem_stall_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL lw_c0: got stall=%b req=%b expected 1/0", mem_stall_o, req_o); end
        @(negedge clk); addr_ok_i = 1; #1;
        tests++; if (mem_stall_o !== 1'b1 || req_o !== 1'b1) begin fails++; $display("FAIL lw_c1: got stall=%b req=%b expected 1/1", mem_stall_o, req_o); end
        tests++; if (addr_o !== 32'h8000_0010 || wr_o !== 1'b0 || size_o !== 2'd2) begin fails++; $display("FAIL lw_bus: got addr=%h wr=%b size=%0d expected 80000010/0/2", addr_o, wr_o, size_o); end
        @(negedge clk); addr_ok_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL lw_c2: got stall=%b req=%b expected 1/0", mem_stall_o, req_o); end
        @(negedge clk); data_ok_i = 1; rdata_i = 32'hDEAD_BEEF; #1;
        tests++; if (mem_stall_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL lw_c3: got stall=%b req=%b expected 1/0", mem_stall_o, req_o); end
        @(negedge clk); data_ok_i = 0; rdata_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b0 || rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_c4: got stall=%b rdata=%h expected 0/deadbeef", mem_stall_o, rdata_o); end
        @(negedge clk); mem_en_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b0 || req_o !== 1'b0) begin fails++; $display("FAIL lw_c5: got stall=%b req=%b expected 0/0", mem_stall_o, req_o); end
    endtask

    task automatic test_store_half();
        @(negedge clk); mem_en_i = 1; mem_wr_i = 1; mem_size_i = 1; mem_addr_i = 32'h8000_0022; mem_wdata_i = 32'h1234_0000; #1;
        tests++; if (mem_stall_o !== 1'b1) begin fails++; $display("FAIL sh_c0_stall: got %b expected 1", mem_stall_o); end
        @(negedge clk); addr_ok_i = 1; data_ok_i = 1; rdata_i = 32'h5555_5555; #1;
        tests++; if (req_o !== 1'b1 || wr_o !== 1'b1 || size_o !== 2'd1) begin fails++; $display("FAIL sh_c1_ctl: got req=%b wr=%b size=%0d expected 1/1/1", req_o, wr_o, size_o); end
        tests++; if (addr_o !== 32'h8000_0022 || wdata_o !== 32'h1234_0000) begin fails++; $display("FAIL sh_c1_bus: got addr=%h wdata=%h expected 80000022/12340000", addr_o, wdata_o); end
        @(negedge clk); addr_ok_i = 0; data_ok_i = 0; rdata_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b0 || req_o !== 1'b0) begin fails++; $display("FAIL sh_c2_done: got stall=%b req=%b expected 0/0", mem_stall_o, req_o); end
        tests++; if (rdata_o !== 32'hDEAD_BEEF) begin fails++; $display("FAIL sh_rdata_kept: got %h expected deadbeef", rdata_o); end
        @(negedge clk); mem_en_i = 0; mem_wr_i = 0; #1;
    endtask

    task automatic test_except();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2; mem_addr_i = 32'h8000_0013; except_i = 1; #1;
            tests++; if (req_o !== 1'b0 || mem_stall_o !== 1'b0) begin fails++; $display("FAIL except_c%0d: got req=%b stall=%b expected 0/0", i, req_o, mem_stall_o); end
        end
        @(negedge clk); mem_en_i = 0; except_i = 0; #1;
        tests++; if (req_o !== 1'b0) begin fails++; $display("FAIL except_after: got req=%b expected 0", req_o); end
    endtask

    task automatic test_addr_hold();
        @(negedge clk); mem_en_i = 1; mem_wr_i = 0; mem_size_i = 0; mem_addr_i = 32'h8000_0033; #1;
        @(negedge clk); mem_addr_i = 32'h0000_0000; mem_size_i = 2; #1;
        for (int i = 0; i < 4; i++) begin
            tests++; if (req_o !== 1'b1 || addr_o !== 32'h8000_0033 || size_o !== 2'd0 || wr_o !== 1'b0 || mem_stall_o !== 1'b1)
                begin fails++; $display("FAIL hold_c%0d: got req=%b addr=%h size=%0d wr=%b stall=%b expected 1/80000033/0/0/1", i, req_o, addr_o, size_o, wr_o, mem_stall_o); end
            if (i < 3) begin @(negedge clk); #1; end
        end
        addr_ok_i = 1; data_ok_i = 1; rdata_i = 32'hA5A5_A5A5;
        @(negedge clk); addr_ok_i = 0; data_ok_i = 0; rdata_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b0 || rdata_o !== 32'hA5A5_A5A5 || req_o !== 1'b0) begin fails++; $display("FAIL hold_done: got stall=%b rdata=%h req=%b expected 0/a5a5a5a5/0", mem_stall_o, rdata_o, req_o); end
        @(negedge clk); mem_en_i = 0; #1;
    endtask

    task automatic test_pipe_stall();
        @(negedge clk); mem_en_i = 1; mem_wr_i = 0; mem_size_i = 3; mem_addr_i = 32'h8000_0040; #1;
        @(negedge clk); addr_ok_i = 1; data_ok_i = 1; rdata_i = 32'h0BAD_F00D; #1;
        tests++; if (req_o !== 1'b1 || size_o !== 2'd2) begin fails++; $display("FAIL ps_size3: got req=%b size=%0d expected 1/2", req_o, size_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); addr_ok_i = 0; data_ok_i = 0; rdata_i = 32'hFFFF_0000; pipe_stall_i = 1; #1;
            tests++; if (mem_stall_o !== 1'b0 || rdata_o !== 32'h0BAD_F00D || req_o !== 1'b0) begin fails++; $display("FAIL ps_hold_c%0d: got stall=%b rdata=%h req=%b expected 0/0badf00d/0", i, mem_stall_o, rdata_o, req_o); end
        end
        @(negedge clk); pipe_stall_i = 0; #1;
        tests++; if (mem_stall_o !== 1'b0) begin fails++; $display("FAIL ps_release: got stall=%b expected 0", mem_stall_o); end
        @(negedge clk); mem_addr_i = 32'h8000_0044; mem_size_i = 2; #1;
        tests++; if (mem_stall_o !== 1'b1 || req_o !== 1'b0) begin fails++; $display("FAIL ps_idle: got stall=%b req=%b expected 1/0", mem_stall_o, req_o); end
        @(negedge clk); addr_ok_i = 1; data_ok_i = 1; rdata_i = 32'h1111_1111; #1;
        tests++; if (req_o !== 1'b1 || addr_o !== 32'h8000_0044) begin fails++; $display("FAIL ps_next_req: got req=%b addr=%h expected 1/80000044", req_o, addr_o); end
        @(negedge clk); addr_ok_i = 0; data_ok_i = 0; rdata_i = 0; #1;
        tests++; if (rdata_o !== 32'h1111_1111) begin fails++; $display("FAIL ps_next_data: got %h expected 11111111", rdata_o); end
        @(negedge clk); mem_en_i = 0; #1;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk); mem_en_i = 1; mem_wr_i = 0; mem_size_i = 2; mem_addr_i = 32'h8000_0050; #1;
        @(negedge clk); addr_ok_i = 1; #1;
        @(negedge clk); addr_ok_i = 0; #1;
        tests++; if (req_o !== 1'b0 || mem_stall_o !== 1'b1) begin fails++; $display("FAIL rw_wait: got req=%b stall=%b expected 0/1", req_o, mem_stall_o); end
        rst = 1; #1;
        tests++; if (req_o !== 1'b0 || rdata_o !== 32'h0 || addr_o !== 32'h0) begin fails++; $display("FAIL rw_async: got req=%b rdata=%h addr=%h expected 0/0/0", req_o, rdata_o, addr_o); end
        @(negedge clk); rst = 0; mem_en_i = 0; data_ok_i = 1; rdata_i = 32'hFFFF_FFFF; #1;
        tests++; if (rdata_o !== 32'h0 || mem_stall_o !== 1'b0) begin fails++; $display("FAIL rw_stray: got rdata=%h stall=%b expected 0/0", rdata_o, mem_stall_o); end
        @(negedge clk); data_ok_i = 0; rdata_i = 0; #1;
        tests++; if (rdata_o !== 32'h0 || req_o !== 1'b0) begin fails++; $display("FAIL rw_after: got rdata=%h req=%b expected 0/0", rdata_o, req_o); end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_store_half();
        test_except();
        test_addr_hold();
        test_pipe_stall();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
